hazard_scoreboard: RTL

Parametrised pipeline hazard unit for the five-stage MIPS core: it generates stall/flush controls and forwarding selects for D-stage and E-stage operands. It succeeds the fixed two-port hazard unit, adding the following:
- configurable read-port count and forwarding depth;
- a busy scoreboard for the multi-cycle multiply/divide unit;
- per-cause stall performance counters.

It sits beside the datapath and is driven by the decode, execute and memory stages and by the I/D bus handshakes.

---
 rtl/hazard_pkg.sv | 19 +
 rtl/hazard_fwd_sel.sv | 28 ++
 rtl/hazard_scoreboard.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard unit: forwarding select encoding,
// producer stage numbering and stall cause classification.
package hazard_pkg;
    localparam int FWD_STAGES = 3;

    typedef logic [$clog2(FWD_STAGES+1)-1:0] fwd_sel_t;

    localparam int STG_E = 1;
    localparam int STG_M = 2;
    localparam int STG_W = 3;

    typedef enum logic [2:0] {
        SC_NONE,
        SC_LOAD,
        SC_MD,
        SC_IFETCH,
        SC_MEM
    } stall_cause_e;
endpackage

// File: rtl/hazard_fwd_sel.sv
// Single-port forwarding priority comparator over producer stages FIRST..NFWD.
// Purely combinational; the youngest matching producer wins, r0 never forwards.
module hazard_fwd_sel
    import hazard_pkg::*;
#(
    parameter int FIRST = 1,
    parameter int NFWD  = 3
) (
    input  logic [4:0]           src,
    input  logic [NFWD:1]        wr_en,
    input  logic [NFWD:1][4:0]   wr_dst,
    output fwd_sel_t             sel
);

    // Stages below FIRST are never selectable from this consumer.
    logic unused_ports;
    assign unused_ports = ^{wr_en, wr_dst};

    always_comb begin
        sel = '0;
        for (int k = NFWD; k >= FIRST; k--) begin
            if (wr_en[k] && (wr_dst[k] == src) && (src != 5'd0)) begin
                sel = fwd_sel_t'(k);
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard unit: combinational stall/flush/forwarding controls, registered mult/div
// busy scoreboard and per-cause stall counters; no handshake of its own.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NREAD  = 2,
    parameter int NFWD   = 3,
    parameter int MD_LAT = 32,
    parameter int CNT_W  = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_valid,
    input  logic                    i_data_ok,
    input  logic                    d_valid,
    input  logic                    d_data_ok,
    input  logic                    br_d,
    input  logic [NREAD-1:0][4:0]   src_d,
    input  logic [NREAD-1:0][4:0]   src_e,
    input  logic [NFWD:1]           wr_en,
    input  logic [NFWD:1]           wr_load,
    input  logic [NFWD:1][4:0]      wr_dst,
    input  logic                    md_start_e,
    input  logic                    md_use_d,
    input  logic                    perf_clr,
    output logic                    stall_f,
    output logic                    stall_d,
    output logic                    stall_e,
    output logic                    stall_m,
    output logic                    flush_e,
    output logic                    flush_w,
    output fwd_sel_t [NREAD-1:0]    fwd_d,
    output fwd_sel_t [NREAD-1:0]    fwd_e,
    output logic                    md_busy,
    output logic [CNT_W-1:0]        cnt_mem,
    output logic [CNT_W-1:0]        cnt_ifetch,
    output logic [CNT_W-1:0]        cnt_md,
    output logic [CNT_W-1:0]        cnt_load
);

    localparam int CW = $clog2(MD_LAT);

    logic          load_stall;
    logic          md_stall;
    logic          i_stall;
    logic          d_stall;
    logic          hit_e;
    logic          hit_m;
    logic          md_accept;
    logic [CW-1:0] md_cnt;
    stall_cause_e  cause;

    logic unused_load;
    assign unused_load = ^wr_load;

    for (genvar p = 0; p < NREAD; p++) begin : g_port
        hazard_fwd_sel #(.FIRST(STG_E), .NFWD(NFWD)) u_fwd_d (
            .src    (src_d[p]),
            .wr_en  (wr_en),
            .wr_dst (wr_dst),
            .sel    (fwd_d[p])
        );
        // An E-stage consumer is never fed by stage E itself.
        hazard_fwd_sel #(.FIRST(STG_M), .NFWD(NFWD)) u_fwd_e (
            .src    (src_e[p]),
            .wr_en  (wr_en),
            .wr_dst (wr_dst),
            .sel    (fwd_e[p])
        );
    end

    always_comb begin
        hit_e = 1'b0;
        hit_m = 1'b0;
        for (int p = 0; p < NREAD; p++) begin
            if (src_d[p] != 5'd0) begin
                if (wr_dst[STG_E] == src_d[p]) hit_e = 1'b1;
                if (wr_dst[STG_M] == src_d[p]) hit_m = 1'b1;
            end
        end
    end

    // A branch resolving in D needs its operands a stage earlier, so a load in M also hurts.
    assign load_stall = (wr_load[STG_E] & wr_en[STG_E] & hit_e)
                      | (br_d & wr_load[STG_M] & wr_en[STG_M] & hit_m);
    assign md_stall   = md_use_d & md_busy;
    assign i_stall    = i_valid & ~i_data_ok;
    assign d_stall    = d_valid & ~d_data_ok;

    assign stall_f = load_stall | md_stall | i_stall | d_stall;
    assign stall_d = stall_f;
    assign stall_e = d_stall;
    assign stall_m = d_stall;
    assign flush_w = d_stall;
    assign flush_e = (load_stall | md_stall | i_stall) & ~d_stall;

    assign md_accept = md_start_e & ~stall_e;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            md_cnt  <= '0;
            md_busy <= 1'b0;
        end else if (md_accept) begin
            md_cnt  <= CW'(MD_LAT - 1);
            md_busy <= 1'b1;
        end else if (md_cnt != '0) begin
            md_cnt  <= md_cnt - CW'(1);
        end else begin
            md_busy <= 1'b0;
        end
    end

    always_comb begin
        if (d_stall)         cause = SC_MEM;
        else if (i_stall)    cause = SC_IFETCH;
        else if (md_stall)   cause = SC_MD;
        else if (load_stall) cause = SC_LOAD;
        else                 cause = SC_NONE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_mem    <= '0;
            cnt_ifetch <= '0;
            cnt_md     <= '0;
            cnt_load   <= '0;
        end else if (perf_clr) begin
            cnt_mem    <= '0;
            cnt_ifetch <= '0;
            cnt_md     <= '0;
            cnt_load   <= '0;
        end else begin
            case (cause)
                SC_MEM:    cnt_mem    <= cnt_mem + CNT_W'(1);
                SC_IFETCH: cnt_ifetch <= cnt_ifetch + CNT_W'(1);
                SC_MD:     cnt_md     <= cnt_md + CNT_W'(1);
                SC_LOAD:   cnt_load   <= cnt_load + CNT_W'(1);
                default:   ;
            endcase
        end
    end

endmodule
